div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential integer divider for the RV32M divide group: DIV, DIVU, REM and REMU.
- It is the inverse-direction companion of the combinational multiplier in the M-extension datapath.
- Radix-2 restoring division: one quotient bit per cycle.
- Start/Busy/Done handshake with the execute stage; the result is held until the next completion.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  operation select (funct3[1:0]): 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Dividend  input  DATA_WIDTH  rs1 operand; sampled with Start.
- Divisor  input  DATA_WIDTH  rs2 operand; sampled with Start.
- Result  output  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse; Result is valid from this cycle onward.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; Result=0; Busy=0; Done=0; all internal registers cleared. Reset mid-operation abandons it, with no Done.
- States: IDLE, CALC, FINISH.
- IDLE, Start=1 at edge E0:
  - Latch Op and sign flags. Signed ops use the sign of each operand; unsigned ops use 0.
  - Latch absolute values: two's-complement negate when the sign flag is set.
  - Clear the partial remainder; count=0.
  - Next state is CALC, except in the special cases below, which go directly to FINISH.
- Special cases, detected at E0:
  - Divisor==0: quotient=all ones, remainder=Dividend (unmodified), for both signed and unsigned ops.
  - Signed overflow: DIV/REM with Dividend=0x80000000 and Divisor=0xFFFFFFFF gives quotient=0x80000000, remainder=0.
- CALC, one iteration per edge:
  - Shift {rem, quo} left 1, bringing in the dividend MSB.
  - Trial subtract: rem - |Divisor| using DATA_WIDTH+1 bits.
  - If non-negative, commit the subtraction and set quotient LSB=1; else quotient LSB=0.
  - count increments; after DATA_WIDTH iterations (edge E32) go to FINISH.
- FINISH, one edge (E33 normal, E1 special):
  - Sign fix: quotient negated if the dividend sign differs from the divisor sign (signed ops only).
  - Remainder takes the dividend sign (signed ops only).
  - Register the Op-selected value into Result; Done=1 for exactly this one cycle; state to IDLE.
- Latency: Done high in the cycle after E33 for normal ops, and after E1 for special cases.
- Busy:
  - Goes high from E0 through the edge at which FINISH completes.
  - Is 0 in the Done cycle.
  - Busy = (state != IDLE).
- Start handling:
  - Ignored while Busy=1, with no queuing.
  - Start asserted during the Done cycle is accepted (back-to-back allowed).
- Result holds its value from the last completion until the next FINISH or RST. It is never updated mid-operation.
- Operands may change after E0 without effect.
- Width rules:
  - Internal remainder path is DATA_WIDTH+1 bits.
  - abs(0x80000000) = 0x80000000 is treated as unsigned magnitude, which is correct for all non-overflow cases.

Test Plan:
- DIVU 20/5 (Start one cycle, then low) -> Busy high for 34 cycles; Done after E33; Result=4. Repeat as REMU 23/5 -> Result=3.
- DIV -20/3 -> Result=0xFFFFFFFA (-6). REM -20/3 -> 0xFFFFFFFE (-2). REM 20/-3 -> 2.
- Divide by zero: DIV 7/0 -> Result=0xFFFFFFFF and REM 7/0 -> 7, each with Done after E1 (Busy high 2 cycles).
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; short latency.
- Handshake:
  - Start pulsed again mid-CALC -> ignored; Result unchanged until the first completion.
  - Start held high through Done -> second op accepted at the Done cycle with no idle gap.
- Reset: assert RST at E10 of DIVU 100/7 -> Busy, Done and Result go to 0 immediately (asynchronously). After release, a new DIVU 100/7 -> 14.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the execute stage and the sequential divider.
// The execute stage is the master; the divider is the slave.
interface div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;
    logic                  done;

    modport master (
        output start, op, dividend, divisor,
        input  result, busy, done
    );

    modport slave (
        input  start, op, dividend, divisor,
        output result, busy, done
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Result is held from one completion to the next; Done pulses for a single cycle.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    div_unit_if.slave  div_io
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e                state_q;
    logic [1:0]            op_q;
    logic                  sign_a_q;
    logic                  sign_b_q;
    logic                  special_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [CntW-1:0]       count_q;
    logic                  done_q;

    logic                  is_signed;
    logic                  sign_a;
    logic                  sign_b;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] abs_a;
    logic [DATA_WIDTH-1:0] abs_b;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;

    always_comb begin
        // op[0] set means unsigned (DIVU/REMU)
        is_signed = ~div_io.op[0];
        sign_a    = is_signed & div_io.dividend[DATA_WIDTH-1];
        sign_b    = is_signed & div_io.divisor[DATA_WIDTH-1];
        abs_a     = sign_a ? -div_io.dividend : div_io.dividend;
        abs_b     = sign_b ? -div_io.divisor : div_io.divisor;
        div_zero  = (div_io.divisor == '0);
        overflow  = is_signed & (div_io.dividend == MinNeg) & (div_io.divisor == '1);

        // rem < divisor holds, so the top bit of the (W+1)-bit difference is a valid borrow
        shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
        trial     = shifted - {1'b0, divisor_q};

        quo_fix   = (~special_q & (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
        rem_fix   = (~special_q & sign_a_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (div_io.start) begin
                        op_q      <= div_io.op;
                        sign_a_q  <= sign_a;
                        sign_b_q  <= sign_b;
                        divisor_q <= abs_b;
                        count_q   <= '0;
                        // Special cases preload the final values and skip the iteration
                        if (div_zero) begin
                            quo_q     <= '1;
                            rem_q     <= div_io.dividend;
                            special_q <= 1'b1;
                            state_q   <= StFinish;
                        end else if (overflow) begin
                            quo_q     <= MinNeg;
                            rem_q     <= '0;
                            special_q <= 1'b1;
                            state_q   <= StFinish;
                        end else begin
                            quo_q     <= abs_a;
                            rem_q     <= '0;
                            special_q <= 1'b0;
                            state_q   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (trial[DATA_WIDTH]) begin
                        rem_q <= shifted[DATA_WIDTH-1:0];
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= trial[DATA_WIDTH-1:0];
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
                    end
                    count_q <= count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    result_q <= op_q[1] ? rem_fix : quo_fix;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign div_io.result = result_q;
    assign div_io.busy   = (state_q != StIdle);
    assign div_io.done   = done_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboarded results, latency, handshake and reset checks.
module tb_div_unit;
    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit_if #(.DATA_WIDTH(32)) bus ();

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_io (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives Start across one edge (E0) and returns #1 after it, Start low, operands scrambled.
    task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    endtask

    // Called #1 after edge number lat0 (counted from E0); waits for Done, bounded.
    task automatic wait_done(input string tag, input int exp_lat, input int lat0);
        int lat;
        logic [31:0] exp;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(tag, op, a, b, exp);
        wait_done(tag, lat, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_20_5", OpDivu, 32'd20, 32'd5, 32'd4, 33);
        run_op("remu_23_5", OpRemu, 32'd23, 32'd5, 32'd3, 33);
        run_op("div_m20_3", OpDiv, -32'sd20, 32'd3, 32'hFFFF_FFFA, 33);
        run_op("rem_m20_3", OpRem, -32'sd20, 32'd3, 32'hFFFF_FFFE, 33);
        run_op("rem_20_m3", OpRem, 32'd20, -32'sd3, 32'd2, 33);
        run_op("div_min_2", OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
        run_op("remu_big", OpRemu, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        run_op("divu_big", OpDivu, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33);
        run_op("div_7_0", OpDiv, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_m7_0", OpRem, -32'sd7, 32'd0, 32'hFFFF_FFF9, 1);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("rem_7_0", OpRem, 32'd7, 32'd0, 32'd7, 1);

        // Start pulse mid-CALC must be dropped, and Result must not move before completion
        start_op("mid", OpDivu, 32'd100, 32'd7, 32'd14);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("mid_result_hold", bus.result, 32'd7);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = OpDiv;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("mid", 33, 11);
        @(posedge clk);
        #1;
        check("mid_no_queue_busy", 32'(bus.busy), 32'd0);
        check("mid_no_queue_done", 32'(bus.done), 32'd0);

        // Start held high: second op is taken on the edge ending the Done cycle
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = OpDivu;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        exp_q.push_back(32'd10);
        @(posedge clk);
        #1;
        bus.dividend = 32'd81;
        bus.divisor  = 32'd9;
        exp_q.push_back(32'd9);
        wait_done("b2b_first", 33, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        check("b2b_second_done_low", 32'(bus.done), 32'd0);
        wait_done("b2b_second", 33, 0);

        // Asynchronous reset at E10 abandons the operation
        start_op("rst_mid", OpDivu, 32'd100, 32'd7, 32'd14);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_result", bus.result, 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_no_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_idle_done", 32'(bus.done), 32'd0);
        run_op("after_rst", OpDivu, 32'd100, 32'd7, 32'd14, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
